flappy_game_ctrl_multi: RTL
===========================

Name: flappy_game_ctrl_multi

Overview:
Parametrised next-generation game controller for the VGA flappy game. It supports NUM_PIPES concurrent pipes, an explicit IDLE/PLAY/DEAD state machine, velocity-based bird physics, LFSR hole placement and saturating score. It updates once per frame, on a tick derived from v_sync, and feeds the bit generator and score output.

Parameters:
NUM_PIPES, 2, number of simultaneous pipes (1..4)
V_RES, 480, visible lines
H_RES, 640, visible pixels
BIRD_X, 160, bird left edge (fixed)
BIRD_SIZE, 16, bird square size in pixels
PIPE_W, 40, pipe width
GAP_H, 120, hole height
HOLE_MIN, 40, minimum hole top; HOLE_MIN+255+GAP_H <= V_RES is required
PIPE_SPACING, 320, horizontal distance between pipes; NUM_PIPES*PIPE_SPACING <= 1023 is required
PIPE_SPEED, 2, pixels per frame
GRAVITY, 1, velocity increment per frame
FLAP_VEL, 8, upward speed set by a flap
MAX_FALL, 8, terminal downward speed
SCORE_W, 8, score width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
v_sync  in  1  active-low VGA vsync from the timing generator
button  in  1  raw flap button, asynchronous
bird_y  out  9  bird top row
pipe_x  out  NUM_PIPES*10  packed pipe left edges; pipe i is at [10*i+:10]
hole_y  out  NUM_PIPES*9  packed hole top rows; pipe i is at [9*i+:9]
score  out  SCORE_W  pipes passed, saturating
state  out  2  0=IDLE, 1=PLAY, 2=DEAD
frame_tick  out  1  one-cycle pulse on the v_sync falling edge

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, score=0, velocity=0, flap_req=0.
  - bird_y=(V_RES-BIRD_SIZE)/2.
  - pipe_x[i]=H_RES+i*PIPE_SPACING.
  - hole_y[i]=(V_RES-GAP_H)/2.
  - LFSR=16'hACE1.
- Button input: 2-FF synchroniser, then rising-edge detect. An edge sets flap_req. flap_req clears on the frame_tick cycle that consumes it. Multiple edges within one frame count as one flap.
- frame_tick: v_sync is registered; tick = prev 1 and current 0. All game updates occur only on tick cycles and become visible the cycle after the tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk, in every state.
- IDLE:
  - Outputs are held at their reset values.
  - On a tick with flap_req: go to PLAY and apply the flap in that same tick.
- PLAY, per tick:
  - Velocity (signed 6-bit): vel = flap_req ? -FLAP_VEL : min(vel+GRAVITY, MAX_FALL).
  - bird_y += vel. A negative result clamps to 0.
  - Floor: if bird_y+BIRD_SIZE >= V_RES, clamp bird_y to V_RES-BIRD_SIZE and go to DEAD.
  - Pipe move: each pipe moves pipe_x -= spd.
  - Pipe wrap: if pipe_x < spd, then pipe_x = pipe_x + NUM_PIPES*PIPE_SPACING - spd, and hole_y = HOLE_MIN + lfsr[7:0]. The LFSR is sampled once per tick; multiple wrapping pipes use lfsr[7:0], lfsr[15:8], and so on in rotation.
  - Score: +1 per pipe whose right edge crosses BIRD_X, i.e. old pipe_x+PIPE_W > BIRD_X and new pipe_x+PIPE_W <= BIRD_X. Simultaneous crossings add their count. Score saturates at all-ones.
  - Collision is checked on the updated values. It occurs when the x ranges [BIRD_X, BIRD_X+BIRD_SIZE) and [pipe_x, pipe_x+PIPE_W) overlap, and either bird_y < hole_y or bird_y+BIRD_SIZE > hole_y+GAP_H. A collision moves the state to DEAD.
  - Collision or floor takes precedence over scoring in the same tick: score is not incremented.
- DEAD:
  - All positions and score are frozen.
  - A tick with flap_req goes to IDLE, which reloads the reset values except the LFSR.
- Reset mid-game: immediate return to the reset values.

Optional Feature:
SPEEDUP_EN
- Defined: spd = min(PIPE_SPEED + score[SCORE_W-1:3], 2*PIPE_SPEED), i.e. speed rises every 8 points.
- Undefined: spd = PIPE_SPEED constant.
- The wrap and crossing rules use the current spd.

Decomposition:
- Package flappy_pkg holds:
  - the game_state_t enum (IDLE/PLAY/DEAD);
  - the default geometry and physics constants;
  - the LFSR seed and taps.
- One sub-module, flappy_lfsr16: free-running LFSR with asynchronous active-high reset.
- Everything else is implemented in flappy_game_ctrl_multi.

Test Plan:
1. Reset with rst=1 mid-PLAY -> state=0, score=0, bird_y=232, pipe_x={960,640}, hole_y={180,180}.
2. Press the button in IDLE, then run 3 ticks with no more presses. Expected vel -8, -7, -6 and bird_y=224, 217, 211; every pipe_x decreases by 2 per tick.
3. Press the button 3 times within one frame -> exactly one flap; flap_req clears at the tick.
4. Hold the bird inside the gap, i.e. force hole_y=bird_y-20, until a pipe right edge passes 160 -> score increments by exactly 1 and state stays PLAY.
5. No presses after entering PLAY -> bird reaches the floor, bird_y=464, state=DEAD; a later press plus tick returns to IDLE with score 0.
6. pipe_x=1 with PIPE_SPEED=2 -> the pipe wraps to 639 and hole_y = 40 + lfsr byte. With SPEEDUP_EN and score=16, pipes move 4 pixels per tick.

Source files
------------

// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Package : flappy_pkg
// Game state encoding, default geometry/physics and LFSR constants.
// Revision: 1.0
// ============================================================================
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int c_num_pipes    = 2;
  localparam int c_v_res        = 480;
  localparam int c_h_res        = 640;
  localparam int c_bird_x       = 160;
  localparam int c_bird_size    = 16;
  localparam int c_pipe_w       = 40;
  localparam int c_gap_h        = 120;
  localparam int c_hole_min     = 40;
  localparam int c_pipe_spacing = 320;
  localparam int c_pipe_speed   = 2;
  localparam int c_gravity      = 1;
  localparam int c_flap_vel     = 8;
  localparam int c_max_fall     = 8;
  localparam int c_score_w      = 8;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/flappy_lfsr16.sv
`default_nettype none
// ============================================================================
// Module : flappy_lfsr16
// Free-running 16-bit Fibonacci LFSR used for pipe hole placement.
// Revision: 1.0
// ============================================================================
module flappy_lfsr16
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & c_lfsr_taps)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= c_lfsr_seed;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/flappy_game_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module : flappy_game_ctrl_multi
// Multi-pipe flappy game controller, updated once per v_sync frame tick.
// Define SPEEDUP_EN to raise pipe speed by one pixel every 8 points.
// Revision: 1.0
// ============================================================================
module flappy_game_ctrl_multi
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES    = c_num_pipes,
  parameter int V_RES        = c_v_res,
  parameter int H_RES        = c_h_res,
  parameter int BIRD_X       = c_bird_x,
  parameter int BIRD_SIZE    = c_bird_size,
  parameter int PIPE_W       = c_pipe_w,
  parameter int GAP_H        = c_gap_h,
  parameter int HOLE_MIN     = c_hole_min,
  parameter int PIPE_SPACING = c_pipe_spacing,
  parameter int PIPE_SPEED   = c_pipe_speed,
  parameter int GRAVITY      = c_gravity,
  parameter int FLAP_VEL     = c_flap_vel,
  parameter int MAX_FALL     = c_max_fall,
  parameter int SCORE_W      = c_score_w
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    v_sync,
  input  logic                    button,
  output logic [8:0]              bird_y,
  output logic [NUM_PIPES*10-1:0] pipe_x,
  output logic [NUM_PIPES*9-1:0]  hole_y,
  output logic [SCORE_W-1:0]      score,
  output logic [1:0]              state,
  output logic                    frame_tick
);

  localparam logic [8:0] c_bird_y_rst = 9'((V_RES - BIRD_SIZE) / 2);
  localparam logic [8:0] c_hole_y_rst = 9'((V_RES - GAP_H) / 2);
  localparam int         c_wrap_add   = NUM_PIPES * PIPE_SPACING;
  localparam int         c_score_max  = (1 << SCORE_W) - 1;

  function automatic logic [9:0] pipe_rst_x(input int idx);
    return 10'(H_RES + idx * PIPE_SPACING);
  endfunction

  game_state_t        state_q, state_d;
  logic               vs_q, btn_s1_q, btn_s2_q, btn_s3_q;
  logic               flap_req_q, flap_req_d;
  logic signed [5:0]  vel_q, vel_d, vel_nx;
  logic [8:0]         bird_y_q, bird_y_d, bird_nx;
  logic [9:0]         pipe_x_q [NUM_PIPES];
  logic [9:0]         pipe_x_d [NUM_PIPES];
  logic [9:0]         pipe_nx  [NUM_PIPES];
  logic [8:0]         hole_y_q [NUM_PIPES];
  logic [8:0]         hole_y_d [NUM_PIPES];
  logic [8:0]         hole_nx  [NUM_PIPES];
  logic [SCORE_W-1:0] score_q, score_d, score_nx;
  logic [15:0]        lfsr;
  logic               tick, btn_rise, floor_hit, pipe_hit, play_dead, do_play;

  flappy_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign tick      = vs_q & ~v_sync;
  assign btn_rise  = btn_s2_q & ~btn_s3_q;
  assign play_dead = floor_hit | pipe_hit;

  // Candidate state for a PLAY tick; only committed when do_play is set.
  always_comb begin : p_physics
    int spd, vel_sum, bird_sum, old_x, new_x, n_wrap, n_cross, score_sum;
    logic [7:0] rnd;
    spd = PIPE_SPEED;
`ifdef SPEEDUP_EN
    spd = PIPE_SPEED + int'(score_q >> 3);
    if (spd > 2 * PIPE_SPEED) spd = 2 * PIPE_SPEED;
`endif
    vel_sum = int'(vel_q) + GRAVITY;
    if (vel_sum > MAX_FALL) vel_sum = MAX_FALL;
    if (flap_req_q) vel_sum = -FLAP_VEL;
    vel_nx = 6'(vel_sum);

    bird_sum = int'(bird_y_q) + vel_sum;
    if (bird_sum < 0) bird_sum = 0;
    floor_hit = (bird_sum + BIRD_SIZE >= V_RES);
    if (floor_hit) bird_sum = V_RES - BIRD_SIZE;
    bird_nx = 9'(bird_sum);

    n_wrap   = 0;
    n_cross  = 0;
    old_x    = 0;
    new_x    = 0;
    rnd      = '0;
    pipe_hit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      old_x      = int'(pipe_x_q[i]);
      hole_nx[i] = hole_y_q[i];
      if (old_x < spd) begin
        // Successive wrapping pipes in one tick take successive LFSR bytes.
        rnd        = n_wrap[0] ? lfsr[15:8] : lfsr[7:0];
        new_x      = old_x + c_wrap_add - spd;
        hole_nx[i] = 9'(HOLE_MIN + int'(rnd));
        n_wrap     = n_wrap + 1;
      end else begin
        new_x = old_x - spd;
      end
      pipe_nx[i] = 10'(new_x);
      if ((old_x + PIPE_W > BIRD_X) && (new_x + PIPE_W <= BIRD_X)) n_cross = n_cross + 1;
      if ((new_x < BIRD_X + BIRD_SIZE) && (new_x + PIPE_W > BIRD_X) &&
          ((bird_sum < int'(hole_nx[i])) || (bird_sum + BIRD_SIZE > int'(hole_nx[i]) + GAP_H)))
        pipe_hit = 1'b1;
    end

    score_sum = int'(score_q) + n_cross;
    if (score_sum > c_score_max) score_sum = c_score_max;
    score_nx = SCORE_W'(score_sum);
  end

  always_comb begin : p_next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick && flap_req_q) state_d = play_dead ? DEAD : PLAY;
      PLAY:    if (tick && play_dead)  state_d = DEAD;
      DEAD:    if (tick && flap_req_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : p_datapath
    do_play    = tick && ((state_q == PLAY) || ((state_q == IDLE) && flap_req_q));
    flap_req_d = (flap_req_q & ~tick) | btn_rise;
    vel_d      = vel_q;
    bird_y_d   = bird_y_q;
    pipe_x_d   = pipe_x_q;
    hole_y_d   = hole_y_q;
    score_d    = score_q;
    if (do_play) begin
      vel_d    = vel_nx;
      bird_y_d = bird_nx;
      pipe_x_d = pipe_nx;
      hole_y_d = hole_nx;
      if (!play_dead) score_d = score_nx;
    end else if (tick && (state_q == DEAD) && flap_req_q) begin
      vel_d    = '0;
      bird_y_d = c_bird_y_rst;
      score_d  = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_d[i] = pipe_rst_x(i);
        hole_y_d[i] = c_hole_y_rst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_state_reg
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      vs_q       <= 1'b1;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_s3_q   <= 1'b0;
      flap_req_q <= 1'b0;
      vel_q      <= '0;
      bird_y_q   <= c_bird_y_rst;
      score_q    <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_x_q[i] <= pipe_rst_x(i);
        hole_y_q[i] <= c_hole_y_rst;
      end
    end else begin
      vs_q       <= v_sync;
      btn_s1_q   <= button;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      flap_req_q <= flap_req_d;
      vel_q      <= vel_d;
      bird_y_q   <= bird_y_d;
      score_q    <= score_d;
      pipe_x_q   <= pipe_x_d;
      hole_y_q   <= hole_y_d;
    end
  end

  always_comb begin : p_outputs
    bird_y     = bird_y_q;
    score      = score_q;
    state      = state_q;
    frame_tick = tick;
  end

  generate
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
      assign pipe_x[10*g +: 10] = pipe_x_q[g];
      assign hole_y[9*g +: 9]   = hole_y_q[g];
    end
  endgenerate

endmodule
`default_nettype wire
